// File: rtl/obi_loader_pkg.sv
// Shared types and width helpers for the OBI loader bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package obi_loader_pkg;

  // One buffered host command: direction, target address and write payload.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam logic [3:0] OBI_BE_FULL = 4'hF;

  // Bits needed to hold an occupancy count in the range 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n storage slots (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obi_loader_fifo.sv
// Generic synchronous FIFO with a one-cycle flush, typed payload.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over push.
module obi_loader_fifo
  import obi_loader_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  input  logic flush_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Index advance that wraps for any depth, not only powers of two.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] idx);
    return (idx == AW'(DEPTH - 1)) ? AW'(0) : idx + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == CW'(0));
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  // Next pointer and occupancy; flush clears everything, including a same-cycle push.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = AW'(0);
      rd_d  = AW'(0);
      cnt_d = CW'(0);
    end else begin
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= AW'(0);
      rd_q  <= AW'(0);
      cnt_q <= CW'(0);
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/obi_loader_bridge.sv
// Host command stream to pipelined OBI master with auto-incrementing address pointer.
// Latency: command reaches OBI req one cycle after acceptance; read data one cycle after rvalid.
// Backpressure: cmd_ready_o drops when the command FIFO is full; req is held until gnt.
module obi_loader_bridge
  import obi_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ADDR_INC        = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        addr_valid_i,
  input  logic [31:0] addr_i,
  input  logic        cmd_valid_i,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        cmd_ready_o,
  input  logic        flush_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        obi_req_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_addr_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_gnt_i,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i
);

  localparam int unsigned OW = cnt_w(MAX_OUTSTANDING);

  cmd_t          cmd_in, cmd_head;
  logic          cmd_full, cmd_empty, cmd_push;
  logic [31:0]   cur_addr;
  logic [31:0]   ptr_q, ptr_d;
  logic [OW-1:0] out_q, out_d;
  logic          gnt_fire, rsp_fire, no_out;
  logic          tag_we, tag_full, tag_empty;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          err_q, err_d;
  logic          unused_tag_state;

  // A freshly loaded base address takes effect for a command in the same cycle.
  assign cur_addr    = addr_valid_i ? {addr_i[31:2], 2'b00} : ptr_q;
  assign cmd_ready_o = ~cmd_full;
  assign cmd_push    = cmd_valid_i & ~cmd_full & ~flush_i;
  assign no_out      = (out_q == OW'(0));

  // Assemble the entry captured on acceptance.
  always_comb begin
    cmd_in       = '0;
    cmd_in.we    = cmd_we_i;
    cmd_in.addr  = cur_addr;
    cmd_in.wdata = cmd_wdata_i;
  end

  obi_loader_fifo #(
    .T     (cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_push),
    .data_i  (cmd_in),
    .pop_i   (gnt_fire),
    .flush_i (flush_i),
    .data_o  (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  // Head of the FIFO drives the bus directly, so it stays put until granted.
  assign obi_req_o   = ~cmd_empty & (out_q < OW'(MAX_OUTSTANDING));
  assign obi_we_o    = ~cmd_empty & cmd_head.we;
  assign obi_addr_o  = cmd_empty ? 32'h0 : cmd_head.addr;
  assign obi_wdata_o = cmd_empty ? 32'h0 : cmd_head.wdata;
  assign obi_be_o    = OBI_BE_FULL;
  assign gnt_fire    = obi_req_o & obi_gnt_i;

  // A response with nothing in flight is flagged and otherwise dropped.
  assign rsp_fire = obi_rvalid_i & ~no_out;

  // Direction of each granted transaction, consumed in order by its response.
  obi_loader_fifo #(
    .T     (logic),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_fire),
    .data_i  (obi_we_o),
    .pop_i   (rsp_fire),
    .flush_i (1'b0),
    .data_o  (tag_we),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // The outstanding counter already gates req, so tag occupancy flags are informational.
  assign unused_tag_state = tag_full ^ tag_empty;

  // Next-state for pointer, outstanding count, read response and sticky error.
  always_comb begin
    ptr_d = cur_addr;
    if (cmd_push) ptr_d = cur_addr + ADDR_INC;

    out_d = out_q;
    case ({gnt_fire, rsp_fire})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    rsp_valid_d = rsp_fire & ~tag_we;
    rsp_rdata_d = rsp_valid_d ? obi_rdata_i : rsp_rdata_q;

    err_d = err_q | (cmd_valid_i & cmd_full) | (obi_rvalid_i & no_out);
  end

  // State registers; reset drops the pointer so the host must reload it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= 32'h0;
      out_q       <= OW'(0);
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign err_o       = err_q;
  assign busy_o      = ~cmd_empty | ~no_out;

endmodule

// File: doc/obi_loader_bridge.md
Name: obi_loader_bridge

Overview:
- Parametrised successor to the MCU-to-X-HEEP loader bridge.
- Accepts a stream of write/read commands from the external host (CW305 MCU side), buffers them in a command FIFO, and issues them as pipelined OBI master transactions with up to MAX_OUTSTANDING in flight.
- Keeps an auto-incrementing address pointer so the host loads a base address once and then streams words.
- Returns read data and exposes busy/error status.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered OBI transactions; 1..4.
- ADDR_INC, 4, byte increment of the address pointer per accepted command.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- addr_valid_i  in  1  load address pointer
- addr_i  in  32  new base address; bits[1:0] forced to 0
- cmd_valid_i  in  1  host command valid
- cmd_we_i  in  1  1=write, 0=read
- cmd_wdata_i  in  32  write data
- cmd_ready_o  out  1  FIFO not full
- flush_i  in  1  discard un-issued FIFO entries
- rsp_valid_o  out  1  read data valid, 1-cycle pulse
- rsp_rdata_o  out  32  read data
- busy_o  out  1  FIFO non-empty OR outstanding != 0
- err_o  out  1  sticky protocol error
- obi_req_o  out  1  OBI request
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  4  OBI byte enable; always 4'hF
- obi_addr_o  out  32  OBI address
- obi_wdata_o  out  32  OBI write data
- obi_gnt_i  in  1  OBI grant
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI response data

Behaviour:
- Reset state: pointer=0, FIFO empty, outstanding=0, err=0.
- Reset values of outputs:
  - cmd_ready_o=1
  - busy_o=0
  - rsp_valid_o=0, rsp_rdata_o=0
  - err_o=0
  - obi_req_o=0, obi_we_o=0, obi_addr_o=0, obi_wdata_o=0
  - obi_be_o=4'hF
- Async reset mid-operation drops all FIFO entries and the outstanding count; host must reload the address.
- Address pointer:
  - addr_valid_i loads {addr_i[31:2],2'b0}.
  - Each accepted command (cmd_valid_i & cmd_ready_o) captures the pointer into its FIFO entry, then pointer += ADDR_INC, wrapping modulo 2^32.
  - addr_valid_i and an accepted command in the same cycle: the command uses the new address; pointer becomes new address + ADDR_INC.
- Command FIFO:
  - Entry = {we, addr, wdata}.
  - cmd_ready_o = !full, combinational from FIFO state.
  - Simultaneous push and pop when full is not allowed, because ready is low.
  - Simultaneous push and pop when non-full keeps the count unchanged.
- OBI issue:
  - obi_req_o = !empty & (outstanding < MAX_OUTSTANDING).
  - obi_we_o, obi_addr_o and obi_wdata_o come from the FIFO head and are held stable while req is high and gnt is low.
  - Pop happens on req & gnt.
  - Back-to-back grants are allowed: one transaction per cycle when gnt stays high.
- Outstanding tracking:
  - Counter +1 on req&gnt, -1 on rvalid; both in the same cycle leaves it unchanged.
  - A tag FIFO of depth MAX_OUTSTANDING records we per grant and pops on rvalid.
- Read response:
  - When rvalid arrives and the tag is a read: rsp_valid_o=1 and rsp_rdata_o=obi_rdata_i on the next clock (latency 1).
  - rsp_rdata_o holds its value until the next read response.
  - Write responses are consumed silently.
- Flush:
  - flush_i empties the command FIFO in one cycle; an entry being granted that same cycle still completes.
  - Outstanding transactions always complete.
  - Pointer is unchanged.
  - A command push in the flush cycle is dropped.
- err_o is set (sticky until reset) on either condition:
  - obi_rvalid_i while outstanding == 0; the response is ignored.
  - cmd_valid_i while full.

Decomposition:
- Package obi_loader_pkg holds:
  - cmd_t struct {we, addr[31:0], wdata[31:0]}
  - OBI_BE_FULL = 4'hF
  - localparam functions for counter widths ($clog2)
- Sub-module obi_loader_fifo: generic synchronous FIFO parametrised on type and depth, providing push/pop/flush/full/empty.
  - Used for both the command FIFO and the tag FIFO.

Test Plan:
- Load and stream writes:
  - Stimulus: addr_valid with addr_i=0x0000_0180, then 3 writes 0xA,0xB,0xC; gnt tied 1; rvalid 1 cycle after each grant.
  - Required: OBI writes to 0x180, 0x184, 0x188 in consecutive cycles; busy_o drops after the 3rd rvalid.
- Same-cycle address and command:
  - Stimulus: addr_valid with 0x1003 together with a write of 0x55.
  - Required: write to 0x1000; the next command goes to 0x1004.
- FIFO full and gnt stall:
  - Stimulus: gnt=0; push 5 commands.
  - Required: cmd_ready_o=0 after 4 pushes; 5th push sets err_o=1; obi_addr/wdata stable throughout the stall.
- Outstanding limit and read return:
  - Stimulus: gnt=1, rvalid delayed 3 cycles, reads to 0x0,0x4,0x8.
  - Required: at most 2 grants before the first rvalid; rsp_valid_o pulses 3 times with matching rdata, each 1 cycle after rvalid.
- Flush and pointer wrap:
  - Stimulus: pointer=0xFFFF_FFFC, two writes, gnt=0, then flush_i.
  - Required: first entry targets 0xFFFF_FFFC, second 0x0; after flush the FIFO is empty, no OBI req, pointer=0x4.
- Spurious rvalid and reset mid-operation:
  - Stimulus: rvalid with nothing outstanding, then assert rst_ni=0 mid-stream.
  - Required: err_o=1 after the spurious rvalid; after reset all outputs return to reset values and err_o=0.
